dcache_writeback_queue: RTL and testbench
=========================================

DCACHE_WRITEBACK_QUEUE -- requirements
Module: dcache_writeback_queue

Interface
REQ-001 Parameters (name, default, meaning): DEPTH, 4, entries (power of two); PADDR_W, 32, physical address bits; BEAT_W, 32, AXI data bits; BEATS, 8, beats per cache line; AXI_ID, 1, AW id value.
REQ-002 clk  in  1  clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 alloc_req  in  1  miss unit requests a victim slot for its current refill.
REQ-005 alloc_addr  in  PADDR_W  victim line address, line-aligned.
REQ-006 alloc_success  out  1  combinational grant of alloc_req this cycle.
REQ-007 alloc_idx  out  log2(DEPTH)  slot granted (tail pointer).
REQ-008 vic_en  in  1  victim line data delivered.
REQ-009 vic_idx  in  log2(DEPTH)  slot being filled.
REQ-010 vic_dirty  in  1  victim needs write-back.
REQ-011 vic_data  in  BEATS*BEAT_W  victim line; beat 0 in LSBs.
REQ-012 chk_addr  in  PADDR_W  line address the miss unit is about to fetch.
REQ-013 chk_hit  out  1  combinational: chk_addr matches an occupied slot.
REQ-014 aw_valid/aw_ready  out/in  1  AXI write-address handshake; aw_addr PADDR_W, aw_id, aw_len 8 (=BEATS-1), aw_size 3 (=log2(BEAT_W/8)), aw_burst 2 (=INCR).
REQ-015 w_valid/w_ready  out/in  1  AXI write-data handshake; w_data BEAT_W, w_strb BEAT_W/8 (all ones), w_last 1.
REQ-016 b_valid/b_ready  in/out  1  AXI response handshake; b_resp 2 in.
REQ-017 wb_err  out  1  registered one-cycle pulse when b_resp != OKAY.
REQ-018 empty  out  1  no slot occupied.

Function
REQ-019 Slot states: FREE, WAIT (allocated, data pending), READY (data present, dirty). Circular queue, head/tail pointers wrap modulo DEPTH; count register 0..DEPTH.
REQ-020 alloc_success = alloc_req & (count < DEPTH); on grant tail slot -> WAIT, address stored, tail+1. Count is the registered value: a free in the same cycle does not make room until next cycle.
REQ-021 vic_en to a WAIT slot: vic_dirty=1 -> READY, data stored; vic_dirty=0 -> slot marked CLEAN (freed without AXI when it reaches head). vic_en to a non-WAIT slot is ignored.
REQ-022 Write FSM states IDLE, AW, W, B. IDLE->AW when head slot READY; IDLE frees head in one cycle (head+1, count-1) when head slot is CLEAN; otherwise stays IDLE (in-order, WAIT head blocks).
REQ-023 AW: aw_valid=1, aw_addr=head address; aw_valid held with stable payload until aw_ready; on handshake ->W, beat counter=0.
REQ-024 W: w_valid=1, w_data=beat[counter]; counter increments per w_ready handshake; w_last=1 when counter=BEATS-1; handshake with w_last ->B. w_valid never asserted before AW handshake.
REQ-025 B: b_ready=1; on b_valid slot -> FREE, head+1, count-1, ->IDLE; wb_err pulses next cycle if b_resp!=0. Slot freed regardless of response.
REQ-026 Simultaneous alloc and free: count += grant - free; both pointers move.
REQ-027 chk_hit = OR over slots not FREE of (addr == chk_addr), including the slot in AW/W/B until B handshake completes; comparison excludes a slot granted in the same cycle.
REQ-028 empty = (count == 0).
REQ-029 Latency: READY head to aw_valid = 1 cycle; with ready always high, AW-to-last-W = BEATS cycles.

Reset
REQ-030 On rst: all slots FREE, head=tail=count=0, FSM=IDLE, aw_valid=w_valid=b_ready=0, wb_err=0, empty=1, alloc_success reflects count=0 (=alloc_req). Reset mid-burst abandons the transaction; no further AXI outputs asserted.

Verification
REQ-031 Single dirty eviction: alloc addr 0x8000_0040, vic_en dirty, data beats 0..7 = 0x11..0x88; ready high -> one AW (addr 0x8000_0040, len 7), eight W beats in order, w_last on 0x88, slot freed on B, empty=1.
REQ-032 Clean victim: alloc then vic_dirty=0 -> no aw_valid, slot freed within 2 cycles, chk_hit drops.
REQ-033 Full: four allocs without data -> fifth alloc_success=0; vic data to slot 0 and completed B -> next-cycle alloc_success=1 with alloc_idx=0 (wrap).
REQ-034 Backpressure: aw_ready low 5 cycles, w_ready toggling -> aw/w payload stable while stalled, exactly 8 beats, beat order preserved.
REQ-035 Hazard: chk_addr equal to slot in W state -> chk_hit=1 until B handshake, 0 the cycle after.
REQ-036 Error/reset: b_resp=SLVERR -> wb_err one pulse, slot freed; rst asserted during W -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/dcache_writeback_queue.sv
// Data-cache victim write-back queue: holds evicted lines in a circular buffer and
// drains dirty ones in order as single AXI INCR bursts; clean victims retire silently.
module dcache_writeback_queue #(
    parameter int DEPTH   = 4,
    parameter int PADDR_W = 32,
    parameter int BEAT_W  = 32,
    parameter int BEATS   = 8,
    parameter int AXI_ID  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alloc_req,
    input  logic [PADDR_W-1:0]          alloc_addr,
    output logic                        alloc_success,
    output logic [$clog2(DEPTH)-1:0]    alloc_idx,
    input  logic                        vic_en,
    input  logic [$clog2(DEPTH)-1:0]    vic_idx,
    input  logic                        vic_dirty,
    input  logic [BEATS*BEAT_W-1:0]     vic_data,
    input  logic [PADDR_W-1:0]          chk_addr,
    output logic                        chk_hit,
    output logic                        aw_valid,
    input  logic                        aw_ready,
    output logic [PADDR_W-1:0]          aw_addr,
    output logic [3:0]                  aw_id,
    output logic [7:0]                  aw_len,
    output logic [2:0]                  aw_size,
    output logic [1:0]                  aw_burst,
    output logic                        w_valid,
    input  logic                        w_ready,
    output logic [BEAT_W-1:0]           w_data,
    output logic [BEAT_W/8-1:0]         w_strb,
    output logic                        w_last,
    input  logic                        b_valid,
    output logic                        b_ready,
    input  logic [1:0]                  b_resp,
    output logic                        wb_err,
    output logic                        empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

    typedef enum logic [1:0] {SLOT_FREE, SLOT_WAIT, SLOT_READY, SLOT_CLEAN} slot_t;
    typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} wr_state_t;

    slot_t                   slot_state_r [DEPTH];
    logic [PADDR_W-1:0]      slot_addr_r  [DEPTH];
    logic [BEATS*BEAT_W-1:0] slot_data_r  [DEPTH];
    logic [IDX_W-1:0]        head_r;
    logic [IDX_W-1:0]        tail_r;
    logic [IDX_W:0]          count_r;
    wr_state_t               state_r;
    wr_state_t               state_nxt_s;
    logic [BC_W-1:0]         beat_r;
    logic                    wb_err_r;

    logic                    grant_s;
    logic                    free_s;
    logic                    aw_hs_s;
    logic                    w_hs_s;
    logic                    b_hs_s;
    logic                    last_beat_s;
    slot_t                   head_state_s;
    logic [BEAT_W-1:0]       head_beats_s [BEATS];

    assign grant_s      = alloc_req & (count_r < DEPTH_C);
    assign head_state_s = slot_state_r[head_r];
    assign aw_hs_s      = (state_r == ST_AW) & aw_ready;
    assign w_hs_s       = (state_r == ST_W) & w_ready;
    assign b_hs_s       = (state_r == ST_B) & b_valid;
    assign last_beat_s  = (beat_r == BC_W'(BEATS-1));
    // A clean head retires straight from IDLE; a dirty one only after its B response
    assign free_s       = ((state_r == ST_IDLE) & (head_state_s == SLOT_CLEAN)) | b_hs_s;

    assign alloc_success = grant_s;
    assign alloc_idx     = tail_r;
    assign empty         = (count_r == '0);
    assign wb_err        = wb_err_r;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (grant_s) tail_r <= tail_r + IDX_W'(1);
            else         tail_r <= tail_r;
            if (free_s)  head_r <= head_r + IDX_W'(1);
            else         head_r <= head_r;
            case ({grant_s, free_s})
                2'b10:   count_r <= count_r + (IDX_W+1)'(1);
                2'b01:   count_r <= count_r - (IDX_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Per-slot lifecycle; grant and free never target the same slot in one cycle
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst)
                slot_state_r[i] <= SLOT_FREE;
            else if (grant_s && (tail_r == IDX_W'(i)))
                slot_state_r[i] <= SLOT_WAIT;
            else if (free_s && (head_r == IDX_W'(i)))
                slot_state_r[i] <= SLOT_FREE;
            else if (vic_en && (vic_idx == IDX_W'(i)) && (slot_state_r[i] == SLOT_WAIT))
                slot_state_r[i] <= vic_dirty ? SLOT_READY : SLOT_CLEAN;
            else
                slot_state_r[i] <= slot_state_r[i];
        end
    end

    // Address and line storage; contents are qualified by slot state so need no reset
    always_ff @(posedge clk) begin
        if (grant_s)
            slot_addr_r[tail_r] <= alloc_addr;
        if (vic_en && vic_dirty && (slot_state_r[vic_idx] == SLOT_WAIT))
            slot_data_r[vic_idx] <= vic_data;
    end

    // Write FSM state register, beat counter and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            beat_r   <= '0;
            wb_err_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            wb_err_r <= b_hs_s & (b_resp != 2'b00);
            if (aw_hs_s)     beat_r <= '0;
            else if (w_hs_s) beat_r <= beat_r + BC_W'(1);
            else             beat_r <= beat_r;
        end
    end

    // Write FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: state_nxt_s = (head_state_s == SLOT_READY) ? ST_AW : ST_IDLE;
            ST_AW:   state_nxt_s = aw_ready ? ST_W : ST_AW;
            ST_W:    state_nxt_s = (w_ready && last_beat_s) ? ST_B : ST_W;
            ST_B:    state_nxt_s = b_valid ? ST_IDLE : ST_B;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Split the head line into beats, beat 0 from the LSBs
    always_comb begin
        for (int k = 0; k < BEATS; k++) begin
            head_beats_s[k] = slot_data_r[head_r][k*BEAT_W +: BEAT_W];
        end
    end

    // Write FSM outputs; payloads are zero outside their phase
    always_comb begin
        aw_valid = (state_r == ST_AW);
        w_valid  = (state_r == ST_W);
        b_ready  = (state_r == ST_B);
        aw_addr  = (state_r == ST_AW) ? slot_addr_r[head_r] : '0;
        w_data   = (state_r == ST_W) ? head_beats_s[beat_r] : '0;
        w_last   = (state_r == ST_W) & last_beat_s;
        aw_id    = 4'(AXI_ID);
        aw_len   = 8'(BEATS-1);
        aw_size  = 3'($clog2(BEAT_W/8));
        aw_burst = 2'b01;
        w_strb   = {(BEAT_W/8){1'b1}};
    end

    // Hazard lookup against every occupied slot, including one being written back
    always_comb begin
        chk_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            chk_hit = chk_hit | ((slot_state_r[i] != SLOT_FREE) & (slot_addr_r[i] == chk_addr));
        end
    end

endmodule

// File: tb/tb_dcache_writeback_queue.sv
// Directed bench for dcache_writeback_queue: dirty/clean eviction, full queue wrap,
// AXI backpressure, address hazard, error response and mid-burst reset.
module tb_dcache_writeback_queue;

    logic         clk = 1'b0;
    logic         rst;
    logic         alloc_req;
    logic [31:0]  alloc_addr;
    logic         alloc_success;
    logic [1:0]   alloc_idx;
    logic         vic_en;
    logic [1:0]   vic_idx;
    logic         vic_dirty;
    logic [255:0] vic_data;
    logic [31:0]  chk_addr;
    logic         chk_hit;
    logic         aw_valid;
    logic         aw_ready;
    logic [31:0]  aw_addr;
    logic [3:0]   aw_id;
    logic [7:0]   aw_len;
    logic [2:0]   aw_size;
    logic [1:0]   aw_burst;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_data;
    logic [3:0]   w_strb;
    logic         w_last;
    logic         b_valid;
    logic         b_ready;
    logic [1:0]   b_resp;
    logic         wb_err;
    logic         empty;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_beat [8];

    dcache_writeback_queue dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_addr(alloc_addr),
        .alloc_success(alloc_success), .alloc_idx(alloc_idx),
        .vic_en(vic_en), .vic_idx(vic_idx), .vic_dirty(vic_dirty), .vic_data(vic_data),
        .chk_addr(chk_addr), .chk_hit(chk_hit),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id),
        .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
        .wb_err(wb_err), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_line(input logic [31:0] base, input logic [31:0] step);
        for (int k = 0; k < 8; k++) begin
            exp_beat[k] = base + step * k;
            vic_data[k*32 +: 32] = exp_beat[k];
        end
    endtask

    initial begin
        int e;
        rst = 1'b1; alloc_req = 1'b1; alloc_addr = 32'h0; vic_en = 1'b0; vic_idx = 2'd0;
        vic_dirty = 1'b0; vic_data = '0; chk_addr = 32'h0; aw_ready = 1'b0; w_ready = 1'b0;
        b_valid = 1'b0; b_resp = 2'b00;
        cyc(); cyc();
        // reset state
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_aw_valid", 64'(aw_valid), 64'd0);
        check("rst_w_valid", 64'(w_valid), 64'd0);
        check("rst_b_ready", 64'(b_ready), 64'd0);
        check("rst_wb_err", 64'(wb_err), 64'd0);
        check("rst_alloc_success", 64'(alloc_success), 64'd1);
        check("rst_alloc_idx", 64'(alloc_idx), 64'd0);
        alloc_req = 1'b0;
        cyc();
        rst = 1'b0;

        // single dirty eviction with ready always high
        alloc_req = 1'b1; alloc_addr = 32'h8000_0040; chk_addr = 32'h8000_0040;
        aw_ready = 1'b1; w_ready = 1'b1;
        #1;
        check("d_alloc_success", 64'(alloc_success), 64'd1);
        check("d_alloc_idx", 64'(alloc_idx), 64'd0);
        check("d_hit_same_cycle", 64'(chk_hit), 64'd0);
        cyc();
        alloc_req = 1'b0;
        load_line(32'h11, 32'h11);
        vic_en = 1'b1; vic_idx = 2'd0; vic_dirty = 1'b1;
        #1;
        check("d_hit_wait", 64'(chk_hit), 64'd1);
        check("d_not_empty", 64'(empty), 64'd0);
        cyc();
        vic_en = 1'b0;
        check("d_aw_idle", 64'(aw_valid), 64'd0);
        cyc();
        check("d_aw_valid", 64'(aw_valid), 64'd1);
        check("d_aw_addr", 64'(aw_addr), 64'h8000_0040);
        check("d_aw_len", 64'(aw_len), 64'd7);
        check("d_aw_size", 64'(aw_size), 64'd2);
        check("d_aw_burst", 64'(aw_burst), 64'd1);
        check("d_aw_id", 64'(aw_id), 64'd1);
        check("d_w_before_aw", 64'(w_valid), 64'd0);
        cyc();
        for (int k = 0; k < 8; k++) begin
            check("d_w_valid", 64'(w_valid), 64'd1);
            check("d_w_data", 64'(w_data), 64'(exp_beat[k]));
            check("d_w_last", 64'(w_last), 64'(k == 7));
            check("d_w_strb", 64'(w_strb), 64'hF);
            check("d_hit_in_w", 64'(chk_hit), 64'd1);
            cyc();
        end
        check("d_b_ready", 64'(b_ready), 64'd1);
        check("d_w_done", 64'(w_valid), 64'd0);
        check("d_hit_in_b", 64'(chk_hit), 64'd1);
        b_valid = 1'b1; b_resp = 2'b00;
        cyc();
        b_valid = 1'b0;
        check("d_empty_after_b", 64'(empty), 64'd1);
        check("d_hit_after_b", 64'(chk_hit), 64'd0);
        check("d_b_ready_off", 64'(b_ready), 64'd0);
        check("d_no_err", 64'(wb_err), 64'd0);

        // clean victim retires without AXI traffic
        alloc_req = 1'b1; alloc_addr = 32'h1000_0080; chk_addr = 32'h1000_0080;
        #1;
        check("c_alloc_idx", 64'(alloc_idx), 64'd1);
        cyc();
        alloc_req = 1'b0;
        vic_en = 1'b1; vic_idx = 2'd1; vic_dirty = 1'b0;
        #1;
        check("c_hit", 64'(chk_hit), 64'd1);
        cyc();
        vic_en = 1'b0;
        check("c_no_aw_1", 64'(aw_valid), 64'd0);
        check("c_not_empty", 64'(empty), 64'd0);
        cyc();
        check("c_no_aw_2", 64'(aw_valid), 64'd0);
        check("c_empty", 64'(empty), 64'd1);
        check("c_hit_drop", 64'(chk_hit), 64'd0);

        // full queue, then backpressured write-back of slot 0 and wrap to slot 0
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        aw_ready = 1'b0; w_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            alloc_req = 1'b1; alloc_addr = 32'h2000_0000 + 32'h40 * i;
            #1;
            check("f_alloc_success", 64'(alloc_success), 64'd1);
            check("f_alloc_idx", 64'(alloc_idx), 64'(i));
            cyc();
        end
        #1;
        check("f_fifth_denied", 64'(alloc_success), 64'd0);
        cyc();
        alloc_req = 1'b0;
        load_line(32'hA0, 32'h1);
        vic_en = 1'b1; vic_idx = 2'd0; vic_dirty = 1'b1;
        cyc();
        vic_en = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            check("bp_aw_valid", 64'(aw_valid), 64'd1);
            check("bp_aw_addr", 64'(aw_addr), 64'h2000_0000);
            check("bp_w_idle", 64'(w_valid), 64'd0);
            cyc();
        end
        aw_ready = 1'b1;
        #1;
        check("bp_aw_hold", 64'(aw_valid), 64'd1);
        cyc();
        aw_ready = 1'b0;
        e = 0;
        for (int c = 0; c < 40 && e < 8; c++) begin
            w_ready = c[0];
            #1;
            check("bp_w_valid", 64'(w_valid), 64'd1);
            check("bp_w_data", 64'(w_data), 64'(exp_beat[e]));
            check("bp_w_last", 64'(w_last), 64'(e == 7));
            cyc();
            if (w_ready) e++;
        end
        w_ready = 1'b0;
        check("bp_beat_count", 64'(e), 64'd8);
        check("bp_b_ready", 64'(b_ready), 64'd1);
        check("bp_w_off", 64'(w_valid), 64'd0);
        alloc_req = 1'b1; alloc_addr = 32'h3000_0000; b_valid = 1'b1;
        #1;
        check("f_free_same_cycle", 64'(alloc_success), 64'd0);
        cyc();
        b_valid = 1'b0;
        #1;
        check("f_wrap_success", 64'(alloc_success), 64'd1);
        check("f_wrap_idx", 64'(alloc_idx), 64'd0);
        alloc_req = 1'b0;

        // error response on slot 1
        load_line(32'h5000, 32'h1);
        vic_en = 1'b1; vic_idx = 2'd1; vic_dirty = 1'b1; chk_addr = 32'h2000_0040;
        aw_ready = 1'b1; w_ready = 1'b1;
        cyc();
        vic_en = 1'b0;
        cyc();
        check("e_aw_addr", 64'(aw_addr), 64'h2000_0040);
        cyc();
        for (int k = 0; k < 8; k++) cyc();
        check("e_b_ready", 64'(b_ready), 64'd1);
        b_valid = 1'b1; b_resp = 2'b10;
        #1;
        check("e_no_err_yet", 64'(wb_err), 64'd0);
        cyc();
        b_valid = 1'b0; b_resp = 2'b00;
        check("e_err_pulse", 64'(wb_err), 64'd1);
        check("e_slot_freed", 64'(chk_hit), 64'd0);
        cyc();
        check("e_err_once", 64'(wb_err), 64'd0);

        // reset during W abandons the burst
        vic_en = 1'b1; vic_idx = 2'd2; vic_dirty = 1'b1; chk_addr = 32'h2000_0080;
        cyc();
        vic_en = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        check("r_in_w", 64'(w_valid), 64'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("r_w_valid", 64'(w_valid), 64'd0);
        check("r_aw_valid", 64'(aw_valid), 64'd0);
        check("r_b_ready", 64'(b_ready), 64'd0);
        check("r_empty", 64'(empty), 64'd1);
        check("r_hit", 64'(chk_hit), 64'd0);
        cyc(); cyc();
        check("r_stay_quiet", 64'(aw_valid | w_valid | b_ready), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
